// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and types for the seven-segment scanner
package seven_seg_pkg;

    localparam int DIGITS = 4;

    // All segments dark, in active-high form.
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Hex-to-segment table, active-high, bit order {g,f,e,d,c,b,a}; index 15 is leftmost.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        RESET_IDLE,
        SCAN
    } scan_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational nibble to active-high seven-segment decoder
module hex_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - double-buffered 4-digit multiplexed seven-segment scanner
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       value,
    input  logic              load,
    input  logic              blank_lz,
    output logic [DIGITS-1:0] dig,
    output logic [6:0]        seg,
    output logic              frame_done
);

    localparam int              PW      = $clog2(CLK_DIV + 1);
    localparam logic [PW-1:0]   PS_MAX  = PW'(CLK_DIV - 1);
    localparam logic [3:0]      DIG_INV = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
    localparam logic [6:0]      SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [PW-1:0] prescaler;
    logic          tick;
    scan_state_t   state;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [15:0]   disp;
    logic          lz_q;

    logic          wrap;
    logic [1:0]    next_idx;
    logic [15:0]   disp_eff;
    logic          lz_eff;
    logic [3:0]    nibble;
    logic          upper_zero;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_ah;
    logic [3:0]    dig_ah;

    assign tick = (prescaler == PS_MAX);

    // Refresh prescaler: one tick every CLK_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Shadow buffer: the last load before a wrap is the value of the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= value;
        end
    end

    // A load on the wrap-tick cycle bypasses the shadow so it shows in the frame starting now.
    assign wrap     = tick && (state == SCAN) && (idx == 2'd3);
    assign next_idx = (state == SCAN) ? idx + 2'd1 : 2'd0;
    assign disp_eff = wrap ? (load ? value : shadow) : disp;
    assign lz_eff   = wrap ? blank_lz : lz_q;
    assign nibble   = disp_eff[{next_idx, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    // Leading-zero test: the digit and everything to its left are zero; digit 0 never blanks.
    always_comb begin
        upper_zero = 1'b0;
        case (next_idx)
            2'd1:    upper_zero = (disp_eff[15:4] == 12'h000);
            2'd2:    upper_zero = (disp_eff[15:8] == 8'h00);
            2'd3:    upper_zero = (disp_eff[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase
    end

    assign seg_ah = (lz_eff && upper_zero) ? SEG_OFF : dec_seg;
    assign dig_ah = 4'b0001 << next_idx;

    // Scan FSM with registered digit/segment outputs and frame-buffer swap at wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RESET_IDLE;
            idx        <= 2'd0;
            disp       <= '0;
            lz_q       <= 1'b0;
            frame_done <= 1'b0;
            dig        <= DIG_INV;
            seg        <= SEG_OFF ^ SEG_INV;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                case (state)
                    RESET_IDLE: begin
                        state <= SCAN;
                        idx   <= 2'd0;
                    end
                    default: begin
                        idx <= next_idx;
                        if (wrap) begin
                            disp       <= disp_eff;
                            lz_q       <= blank_lz;
                            frame_done <= 1'b1;
                        end
                    end
                endcase
                dig <= dig_ah ^ DIG_INV;
                seg <= seg_ah ^ SEG_INV;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
    } exp_t;

    typedef struct {
        logic [15:0]      value;
        logic             blz;
        logic [3:0][6:0]  segs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  dig;
    logic [6:0]  seg;
    logic        frame_done;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    logic [3:0] prev_dig = 4'hF;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    seven_seg_scanner #(
        .CLK_DIV        (4),
        .DIG_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .blank_lz   (blank_lz),
        .dig        (dig),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [3:0][6:0] segs);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.dig = ~(4'b0001 << k);
            e.seg = segs[k];
            sb.push_back(e);
        end
    endtask

    // Waits for a fresh occurrence of digit pattern d (a change into d).
    task automatic wait_dig_edge(input logic [3:0] d);
        bit seen_other = 1'b0;
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dig != d) seen_other = 1'b1;
            else if (seen_other) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_dig_timeout", {28'h0, dig}, {28'h0, d});
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_frame_timeout", 32'd0, 32'd1);
    endtask

    // Output monitor: each new digit slot is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (!(dig == 4'hF || $countones(~dig) == 1)) begin
                n_fail++;
                $display("FAIL dig_onehot: got %b (cycle %0d)", dig, cyc);
            end
        end
        if (mon_en && !rst && dig != prev_dig && sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("scan_dig", {28'h0, dig}, {28'h0, mon_e.dig});
            check("scan_seg", {25'h0, seg}, {25'h0, mon_e.seg});
        end
        prev_dig = dig;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int last_cyc;

        vecs[0] = '{16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'h0050, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
        vecs[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{16'h89AB, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03}};
        vecs[5] = '{16'hCDEF, 1'b0, {7'h46, 7'h21, 7'h06, 7'h0E}};
        vecs[6] = '{16'h0706, 1'b1, {7'h7F, 7'h78, 7'h40, 7'h02}};
        vecs[7] = '{16'h1000, 1'b1, {7'h79, 7'h40, 7'h40, 7'h40}};

        // Reset state and first-tick latency
        repeat (5) @(negedge clk);
        check("rst_dig", {28'h0, dig}, 32'hF);
        check("rst_seg", {25'h0, seg}, 32'h7F);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_tick_dig", {28'h0, dig}, 32'hF);
        @(negedge clk);
        check("first_tick_dig", {28'h0, dig}, 32'hE);
        check("first_tick_seg", {25'h0, seg}, 32'h40);
        mon_en = 1'b1;

        // Table-driven frames: load during digit 3, shown from the next wrap
        for (int i = 0; i < 8; i++) begin
            wait_dig_edge(4'b0111);
            value = vecs[i].value;
            blank_lz = vecs[i].blz;
            load = 1'b1;
            @(posedge clk);
            push_frame(vecs[i].segs);
            @(negedge clk);
            load = 1'b0;
        end

        // Mid-frame loads leave the current frame intact; last load wins
        wait_dig_edge(4'b0111);
        value = 16'h9876;
        blank_lz = 1'b0;
        load = 1'b1;
        @(posedge clk);
        push_frame({7'h10, 7'h00, 7'h78, 7'h02});
        @(negedge clk);
        load = 1'b0;
        wait_dig_edge(4'b1101);
        value = 16'h1111;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_dig_edge(4'b1011);
        value = 16'hABCD;
        load = 1'b1;
        @(posedge clk);
        push_frame({7'h08, 7'h03, 7'h46, 7'h21});
        @(negedge clk);
        load = 1'b0;

        // Load exactly on the wrap-tick cycle goes straight to the display
        wait_dig_edge(4'b0111);
        wait_dig_edge(4'b0111);
        repeat (3) @(posedge clk);
        @(negedge clk);
        value = 16'hEEEE;
        load = 1'b1;
        @(posedge clk);
        push_frame({7'h06, 7'h06, 7'h06, 7'h06});
        @(negedge clk);
        load = 1'b0;
        wait_dig_edge(4'b0111);
        @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        // Asynchronous reset mid-scan
        wait_dig_edge(4'b1011);
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_dig", {28'h0, dig}, 32'hF);
        check("async_rst_seg", {25'h0, seg}, 32'h7F);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("restart_pre_tick_dig", {28'h0, dig}, 32'hF);
        @(negedge clk);
        check("restart_dig", {28'h0, dig}, 32'hE);
        check("restart_seg", {25'h0, seg}, 32'h40);
        wait_frame(ok);
        check("restart_wrap_seg", {25'h0, seg}, 32'h40);
        check("restart_wrap_dig", {28'h0, dig}, 32'hE);

        // Ten frames: frame_done exactly every 16 cycles, aligned with digit 0
        last_cyc = cyc;
        for (int f = 0; f < 10; f++) begin
            wait_frame(ok);
            if (ok) begin
                check("frame_period", cyc - last_cyc, 32'd16);
                check("frame_dig0", {28'h0, dig}, 32'hE);
            end
            last_cyc = cyc;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
